// File: rtl/end_screen_pkg.sv
// Shared types and constants for the end-of-game screen controller.
package end_screen_pkg;

  localparam int COLOR_W = 12;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF     = 12'h000;
  localparam logic [COLOR_W-1:0] TRANSP_COLOR_DEF = 12'hF0F;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    ARMED,
    EXIT
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/overlay_layer.sv
// One rectangular overlay: hit test against the current pixel and the
// row-major image ROM address inside the rectangle (0 when outside).
module overlay_layer
  import end_screen_pkg::*;
#(
  parameter logic [X_W-1:0] X      = '0,
  parameter logic [Y_W-1:0] Y      = '0,
  parameter logic [X_W-1:0] W      = '0,
  parameter logic [Y_W-1:0] H      = '0,
  parameter int             ADDR_W = 16
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  // Bounds widened to 11 bits so origin + size can never wrap.
  localparam logic [10:0] X_LO = 11'(X);
  localparam logic [10:0] X_HI = 11'(X) + 11'(W);
  localparam logic [10:0] Y_LO = 11'(Y);
  localparam logic [10:0] Y_HI = 11'(Y) + 11'(H);

  logic [10:0]       x_w;
  logic [10:0]       y_w;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;

  always_comb begin
    x_w  = 11'(x);
    y_w  = 11'(y);
    hit  = (x_w >= X_LO) && (x_w < X_HI) && (y_w >= Y_LO) && (y_w < Y_HI);
    dx   = ADDR_W'(x_w - X_LO);
    dy   = ADDR_W'(y_w - Y_LO);
    addr = hit ? ADDR_W'(dy * ADDR_W'(W) + dx) : '0;
  end

endmodule

// File: rtl/end_screen_ctrl.sv
// End-of-game screen: holds the win picture for a minimum number of frames,
// then exits on a fresh exit-key press. Optional prompt blink: END_SCREEN_BLINK_EN.
module end_screen_ctrl
  import end_screen_pkg::*;
#(
  parameter int                         NUM_LAYERS   = 2,
  parameter int                         ADDR_W       = 16,
  parameter logic [NUM_LAYERS*X_W-1:0]  LAYER_X      = {10'd254, 10'd105},
  parameter logic [NUM_LAYERS*Y_W-1:0]  LAYER_Y      = {9'd280, 9'd80},
  parameter logic [NUM_LAYERS*X_W-1:0]  LAYER_W      = {10'd380, 10'd380},
  parameter logic [NUM_LAYERS*Y_W-1:0]  LAYER_H      = {9'd143, 9'd112},
  parameter int                         HOLD_FRAMES  = 60,
  parameter int                         BLINK_FRAMES = 30,
  parameter logic [COLOR_W-1:0]         BG_COLOR     = BG_COLOR_DEF,
  parameter logic [COLOR_W-1:0]         TRANSP_COLOR = TRANSP_COLOR_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           success,
  input  logic                           frame_start,
  input  logic [5:0]                     movement,
  input  logic [X_W-1:0]                 x,
  input  logic [Y_W-1:0]                 y,
  output logic [NUM_LAYERS*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_LAYERS*COLOR_W-1:0]  rom_data,
  output logic [COLOR_W-1:0]             color,
  output logic                           win_end
);

  localparam int               CNT_W     = $clog2(max_int(HOLD_FRAMES, BLINK_FRAMES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        frame_cnt;
  logic                    key_prev;
  logic                    key_now;
  logic                    key_rise;
  logic                    unused_keys;
  logic [NUM_LAYERS-1:0]   hit;
  logic [NUM_LAYERS-1:0]   visible;
  logic [COLOR_W-1:0]      pixel;

  assign key_now     = movement[4] | movement[5];
  assign key_rise    = key_now & ~key_prev;
  assign unused_keys = ^movement[3:0];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    overlay_layer #(
      .X      (LAYER_X[i*X_W +: X_W]),
      .Y      (LAYER_Y[i*Y_W +: Y_W]),
      .W      (LAYER_W[i*X_W +: X_W]),
      .H      (LAYER_H[i*Y_W +: Y_W]),
      .ADDR_W (ADDR_W)
    ) u_layer (
      .x    (x),
      .y    (y),
      .hit  (hit[i]),
      .addr (rom_addr[i*ADDR_W +: ADDR_W])
    );
  end

`ifdef END_SCREEN_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // The prompt layer only appears once exit is possible, on even phases.
  always_comb begin
    visible                = '1;
    visible[NUM_LAYERS-1]  = (state == ARMED) && !blink_phase;
  end
`else
  assign visible = '1;
`endif

  // Scan from the highest index down so the lowest opaque layer wins.
  always_comb begin
    pixel = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit[i] && visible[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSP_COLOR)) begin
        pixel = rom_data[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      key_prev  <= 1'b0;
      color     <= BG_COLOR;
      win_end   <= 1'b0;
`ifdef END_SCREEN_BLINK_EN
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
`endif
    end else begin
      key_prev <= key_now;
      win_end  <= (state == EXIT);
      color    <= (state == IDLE) ? BG_COLOR : pixel;
      if (!success) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state     <= SHOW;
            frame_cnt <= '0;
          end
          SHOW: begin
            if (frame_start) begin
              if (frame_cnt == HOLD_LAST) begin
                state <= ARMED;
`ifdef END_SCREEN_BLINK_EN
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
`endif
              end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
          end
          ARMED: begin
`ifdef END_SCREEN_BLINK_EN
            if (frame_start) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
              end
            end
`endif
            if (key_rise) begin
              state <= EXIT;
            end
          end
          EXIT: begin
            state <= EXIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Randomized scoreboard bench for end_screen_ctrl against a frame-level
// behavioural model of the win screen (also models END_SCREEN_BLINK_EN).
module tb_end_screen_ctrl;
  import end_screen_pkg::*;

  localparam int          NL    = 2;
  localparam int          AW    = 16;
  localparam int          HOLD  = 60;
  localparam int          BLINK = 2;
  localparam logic [11:0] BG    = 12'h000;
  localparam logic [11:0] TR    = 12'hF0F;

  // Layer 1 is lowered so the two layers overlap in x 254..484, y 150..191.
  localparam int LX [NL] = '{105, 254};
  localparam int LY [NL] = '{80, 150};
  localparam int LW [NL] = '{380, 380};
  localparam int LH [NL] = '{112, 143};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 success;
  logic                 frame_start;
  logic [5:0]           movement;
  logic [9:0]           x;
  logic [8:0]           y;
  logic [NL*AW-1:0]     rom_addr;
  logic [NL*12-1:0]     rom_data;
  logic [11:0]          color;
  logic                 win_end;

  end_screen_ctrl #(
    .NUM_LAYERS   (NL),
    .ADDR_W       (AW),
    .LAYER_X      ({10'd254, 10'd105}),
    .LAYER_Y      ({9'd150, 9'd80}),
    .LAYER_W      ({10'd380, 10'd380}),
    .LAYER_H      ({9'd143, 9'd112}),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK),
    .BG_COLOR     (BG),
    .TRANSP_COLOR (TR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .success     (success),
    .frame_start (frame_start),
    .movement    (movement),
    .x           (x),
    .y           (y),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .color       (color),
    .win_end     (win_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] color;
    logic        win;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Model: game accepted, frames counted while holding, armed, exited.
  bit m_active, m_armed, m_exited, m_prev_key;
  int m_frames, m_blink;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic bit layer_hit(int i, int px, int py);
    return (px >= LX[i]) && (px < LX[i] + LW[i]) && (py >= LY[i]) && (py < LY[i] + LH[i]);
  endfunction

  function automatic int layer_addr(int i, int px, int py);
    if (!layer_hit(i, px, py)) return 0;
    return ((py - LY[i]) * LW[i] + (px - LX[i])) % (1 << AW);
  endfunction

  function automatic logic [11:0] rand_data();
    return ($urandom_range(0, 3) == 0) ? TR : 12'($urandom);
  endfunction

  task automatic model_reset();
    m_active   = 0;
    m_armed    = 0;
    m_exited   = 0;
    m_prev_key = 0;
    m_frames   = 0;
    m_blink    = 0;
  endtask

  task automatic applyStimulus(input bit s, input bit fs, input logic [5:0] mv,
                               input int px, input int py,
                               input logic [11:0] d0, input logic [11:0] d1);
    exp_t        e;
    bit          key;
    bit          prompt_vis;
    bit          found;
    logic [11:0] data [NL];
    @(negedge clk);
    #1;
    success     = s;
    frame_start = fs;
    movement    = mv;
    x           = 10'(px);
    y           = 9'(py);
    rom_data    = {d1, d0};
    data[0]     = d0;
    data[1]     = d1;
    key         = mv[4] | mv[5];
`ifdef END_SCREEN_BLINK_EN
    prompt_vis = m_armed && !m_exited && (((m_blink / BLINK) % 2) == 0);
`else
    prompt_vis = 1'b1;
`endif
    e.color = BG;
    found   = 0;
    if (m_active) begin
      for (int i = 0; i < NL; i++) begin
        if (!found && layer_hit(i, px, py) && (i != NL - 1 || prompt_vis) && data[i] != TR) begin
          e.color = data[i];
          found   = 1;
        end
      end
    end
    e.win  = m_exited;
    e.addr = {16'(layer_addr(1, px, py)), 16'(layer_addr(0, px, py))};
    sb.push_back(e);
    if (!s) begin
      m_active = 0;
      m_armed  = 0;
      m_exited = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_frames = 0;
    end else if (!m_armed) begin
      if (fs) begin
        m_frames++;
        if (m_frames == HOLD) begin
          m_armed = 1;
          m_blink = 0;
        end
      end
    end else if (!m_exited) begin
      if (fs) m_blink++;
      if (key && !m_prev_key) m_exited = 1;
    end
    m_prev_key = key;
  endtask

  task automatic applyRandom(input bit s, input bit fs, input logic [5:0] mv);
    int px, py, li;
    case ($urandom_range(0, 3))
      0, 1: begin
        li = $urandom_range(0, NL - 1);
        px = LX[li] + $urandom_range(0, LW[li] - 1);
        py = LY[li] + $urandom_range(0, LH[li] - 1);
      end
      2: begin
        li = $urandom_range(0, NL - 1);
        px = LX[li] + LW[li] - $urandom_range(0, 1);
        py = LY[li] + LH[li] - $urandom_range(0, 1);
      end
      default: begin
        px = $urandom_range(0, 639);
        py = $urandom_range(0, 479);
      end
    endcase
    applyStimulus(s, fs, mv, px, py, rand_data(), rand_data());
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput("color", 32'(color), 32'(mon_e.color));
      checkOutput("win_end", 32'(win_end), 32'(mon_e.win));
      checkOutput("rom_addr", 32'(rom_addr), mon_e.addr);
    end
  end

  initial begin
    bit         s_lvl;
    bit         key_lvl;
    logic [5:0] mv;
    rst_n       = 1'b1;
    success     = 1'b0;
    frame_start = 1'b0;
    movement    = '0;
    x           = '0;
    y           = '0;
    rom_data    = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_color", 32'(color), 32'(BG));
    checkOutput("reset_win_end", 32'(win_end), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] idle phase");
    repeat (6) applyRandom(1'b0, 1'($urandom_range(0, 1)), 6'($urandom));

    $display("[TB] show phase with exit key held");
    applyRandom(1'b1, 1'b0, 6'h10);
    applyStimulus(1'b1, 1'b0, 6'h10, 105, 80, 12'h5A5, 12'h777);
    applyStimulus(1'b1, 1'b0, 6'h10, 484, 191, 12'h3C3, 12'h777);
    applyStimulus(1'b1, 1'b0, 6'h10, 300, 160, TR, 12'h123);
    applyStimulus(1'b1, 1'b0, 6'h10, 0, 0, 12'h456, 12'h789);
    applyStimulus(1'b1, 1'b0, 6'h10, 485, 191, 12'h456, 12'h789);
    for (int p = 0; p < HOLD; p++) begin
      applyRandom(1'b1, 1'b1, 6'h10);
      applyRandom(1'b1, 1'b0, 6'h10);
    end

    $display("[TB] armed: held key, release, press");
    repeat (5) applyRandom(1'b1, 1'b0, 6'h10);
    repeat (3) applyRandom(1'b1, 1'b0, 6'h00);
    applyRandom(1'b1, 1'b0, 6'h10);
    repeat (4) applyRandom(1'b1, 1'($urandom_range(0, 1)), 6'($urandom));
    repeat (3) applyRandom(1'b0, 1'b0, 6'h00);

    $display("[TB] random phase");
    s_lvl   = 1;
    key_lvl = 0;
    for (int c = 0; c < 2500; c++) begin
      if (s_lvl) s_lvl = ($urandom_range(0, 299) != 0);
      else       s_lvl = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) key_lvl = ~key_lvl;
      mv      = 6'($urandom);
      mv[5:4] = key_lvl ? 2'($urandom_range(1, 3)) : 2'b00;
      applyRandom(s_lvl, ($urandom_range(0, 2) == 0), mv);
    end

    $display("[TB] exit then asynchronous reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 6'h00, 105, 80, 12'hABC, TR);
    applyStimulus(1'b1, 1'b0, 6'h00, 105, 80, 12'hABC, TR);
    repeat (HOLD) applyStimulus(1'b1, 1'b1, 6'h00, 105, 80, 12'hABC, TR);
    repeat (4) applyStimulus(1'b1, 1'b0, 6'h20, 105, 80, 12'hABC, TR);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_color", 32'(color), 32'(BG));
    checkOutput("async_reset_win_end", 32'(win_end), 32'd0);
    model_reset();
    #3 rst_n = 1'b1;

    $display("[TB] restart after reset discards progress");
    applyStimulus(1'b1, 1'b0, 6'h00, 300, 160, 12'h0F0, 12'h123);
    repeat (HOLD - 1) applyRandom(1'b1, 1'b1, 6'h00);
    applyRandom(1'b1, 1'b0, 6'h10);
    repeat (3) applyRandom(1'b1, 1'b0, 6'h10);
    repeat (2) applyRandom(1'b0, 1'b0, 6'h00);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/end_screen_ctrl.md
END_SCREEN_CTRL -- requirements
Module: end_screen_ctrl

Interface
REQ-001 Parameter NUM_LAYERS, default 2: count of rectangular overlay image layers.
REQ-002 Parameter ADDR_W, default 16: per-layer image ROM address width.
REQ-003 Parameter LAYER_X / LAYER_Y / LAYER_W / LAYER_H, default {254,105} / {280,80} / {380,380} / {143,112}: packed per-layer origin and size, 10/9/10/9 bits per layer; layer 0 in the LSBs.
REQ-004 Parameter HOLD_FRAMES, default 60: minimum frames shown before exit is accepted.
REQ-005 Parameter BLINK_FRAMES, default 30: blink half-period in frames.
REQ-006 Parameter BG_COLOR, default 12'h000; TRANSP_COLOR, default 12'hF0F: background colour and layer transparency key.
REQ-007 clk  in  1  pixel clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 success  in  1  level; game reports win.
REQ-010 frame_start  in  1  one-cycle pulse per frame.
REQ-011 movement  in  6  key levels; bits 4 and 5 are exit keys.
REQ-012 x  in  10 / y  in  9  current pixel coordinate.
REQ-013 rom_addr  out  NUM_LAYERS*ADDR_W  packed per-layer ROM addresses.
REQ-014 rom_data  in  NUM_LAYERS*12  packed per-layer ROM data, asynchronous read.
REQ-015 color  out  12  registered pixel colour.
REQ-016 win_end  out  1  registered; high while in EXIT.

Function
REQ-017 States: IDLE, SHOW, ARMED, EXIT.
REQ-018 IDLE->SHOW when success=1; frame counter cleared on entry.
REQ-019 SHOW: frame counter increments on frame_start; SHOW->ARMED when count reaches HOLD_FRAMES-1 and frame_start=1.
REQ-020 ARMED->EXIT on a rising edge of (movement[4]|movement[5]), detected against a register of the previous cycle's value.
REQ-021 A key held from SHOW into ARMED is not an edge; it must be released and pressed again.
REQ-022 EXIT holds until success=0; any state ->IDLE in the cycle after success=0.
REQ-023 Layer i is hit when LAYER_X[i] <= x < LAYER_X[i]+LAYER_W[i] and LAYER_Y[i] <= y < LAYER_Y[i]+LAYER_H[i]; comparisons use 11-bit widening, so no wrap.
REQ-024 rom_addr[i] = (y-LAYER_Y[i])*LAYER_W[i] + (x-LAYER_X[i]), truncated to ADDR_W; rom_addr[i] is 0 when layer i is not hit.
REQ-025 Colour select: lowest-index hit layer whose data differs from TRANSP_COLOR wins; otherwise the next hit layer; otherwise BG_COLOR.
REQ-026 color is registered: the pixel presented at cycle n appears at cycle n+1.
REQ-027 In IDLE, color=BG_COLOR regardless of x and y.
REQ-028 win_end is registered from (state==EXIT): it rises one cycle after the EXIT transition and falls one cycle after leaving EXIT.
REQ-029 Frame counter saturates at HOLD_FRAMES-1 and is sized $clog2(max(HOLD_FRAMES,BLINK_FRAMES)+1).

Reset
REQ-030 rst_n=0 forces state=IDLE, counters=0, key-edge register=0, color=BG_COLOR and win_end=0, immediately and independent of clk.
REQ-031 Reset asserted mid-SHOW or mid-EXIT discards all progress; after release, a fresh success=1 restarts from SHOW.

Configuration
REQ-032 With macro END_SCREEN_BLINK_EN defined, layer NUM_LAYERS-1 (the prompt layer) is visible only in ARMED and only during even blink phases; a blink counter toggles the phase every BLINK_FRAMES frame_start pulses and is cleared on ARMED entry.
REQ-033 Without END_SCREEN_BLINK_EN, all layers are always visible outside IDLE and no blink counter exists.

Structure
REQ-034 Package end_screen_pkg holds the state enumeration, COLOR_W=12, X_W=10, Y_W=9 and the default BG_COLOR and TRANSP_COLOR.
REQ-035 Sub-module overlay_layer (parameters X, Y, W, H, ADDR_W; outputs hit and addr) is instantiated NUM_LAYERS times through a generate loop.

Verification
REQ-036 success=1, 60 frame_start pulses, no key pressed -> state is ARMED after the 60th pulse; win_end stays 0.
REQ-037 movement[4] held from SHOW entry through ARMED entry -> no EXIT; release, then press -> win_end=1 two cycles after the press.
REQ-038 Default geometry in SHOW, x=105, y=80 -> rom_addr[0]=0, and color equals rom_data[0] one cycle later; x=484, y=191 -> rom_addr[0]=42559.
REQ-039 Pixel where layers 0 and 1 overlap, with rom_data[0]=12'hF0F and rom_data[1]=12'h123 -> color=12'h123; x=0, y=0 -> color=12'h000.
REQ-040 In EXIT, drop success -> state=IDLE and win_end=0 within 2 cycles; then assert rst_n=0 asynchronously mid-clock -> color=12'h000 without waiting for a clock edge.
REQ-041 With END_SCREEN_BLINK_EN and BLINK_FRAMES=2 in ARMED -> prompt layer visible for 2 frames and hidden for the following 2, repeating.
